ear_pulse_conditioner: RTL and testbench

//  Upstream tape-input stage. It conditions the asynchronous cassette EAR pin

---
 rtl/ear_pulse_conditioner_if.sv | 26 ++
 rtl/ear_pulse_conditioner.sv | 130 +++++++++++++
 tb/tb_ear_pulse_conditioner.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ear_pulse_conditioner_if.sv
// rtl/ear_pulse_conditioner_if.sv - pulse-width result and width-FIFO bundle of the EAR conditioner
interface ear_pulse_conditioner_if #(
    parameter int WIDTH_BITS = 16
);
    logic                  pulse_valid;
    logic [WIDTH_BITS-1:0] pulse_width;
    logic                  pulse_level;
    logic                  pulse_sat;
    logic                  fifo_rd;
    logic                  fifo_valid;
    logic [WIDTH_BITS:0]   fifo_dout;
    logic                  fifo_ovf;
    logic                  ovf_clr;

    modport master (
        output pulse_valid, pulse_width, pulse_level, pulse_sat,
        output fifo_valid, fifo_dout, fifo_ovf,
        input  fifo_rd, ovf_clr
    );

    modport slave (
        input  pulse_valid, pulse_width, pulse_level, pulse_sat,
        input  fifo_valid, fifo_dout, fifo_ovf,
        output fifo_rd, ovf_clr
    );
endinterface

// File: rtl/ear_pulse_conditioner.sv
// rtl/ear_pulse_conditioner.sv - EAR synchroniser, glitch filter and pulse-width meter
// Optional width FIFO enabled by defining EAR_PULSE_FIFO_EN.
module ear_pulse_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 16,
    parameter int WIDTH_BITS    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ear_raw,
    output logic ear,
    output logic edge_stb,
    output logic idle,
    ear_pulse_conditioner_if.master pif
);
    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [GW-1:0] GLAST = GW'(GLITCH_CYCLES - 1);
    localparam logic [WIDTH_BITS-1:0] WMAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [GW-1:0]          gcnt;
    logic [WIDTH_BITS-1:0]  wcnt;
    logic                   take;

    assign s    = sync_q[SYNC_STAGES-1];
    assign take = (s != ear) && (gcnt == GLAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ear_raw};
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ear             <= 1'b0;
            gcnt            <= '0;
            edge_stb        <= 1'b0;
            wcnt            <= '0;
            idle            <= 1'b1;
            pif.pulse_valid <= 1'b0;
            pif.pulse_width <= '0;
            pif.pulse_level <= 1'b0;
            pif.pulse_sat   <= 1'b0;
        end else begin
            edge_stb        <= take;
            pif.pulse_valid <= take;
            if (s == ear) begin
                gcnt <= '0;
            end else if (take) begin
                ear  <= s;
                gcnt <= '0;
            end else begin
                gcnt <= gcnt + 1'b1;
            end
            // The edge cycle itself counts toward the pulse, hence wcnt+1.
            if (take) begin
                pif.pulse_width <= (wcnt == WMAX) ? WMAX : wcnt + 1'b1;
                pif.pulse_level <= ear;
                pif.pulse_sat   <= (wcnt == WMAX);
                wcnt            <= '0;
                idle            <= 1'b0;
            end else begin
                if (wcnt != WMAX) begin
                    wcnt <= wcnt + 1'b1;
                end
                if (wcnt >= WMAX - 1'b1) begin
                    idle <= 1'b1;
                end
            end
        end
    end

`ifdef EAR_PULSE_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH_BITS:0] mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;

    assign push    = pif.pulse_valid;
    assign pop     = pif.fifo_rd && pif.fifo_valid;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && (!full || pop);

    assign pif.fifo_valid = (wr_ptr != rd_ptr);
    assign pif.fifo_dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {pif.pulse_level, pif.pulse_width};
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pif.fifo_ovf <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pif.ovf_clr) begin
                pif.fifo_ovf <= 1'b0;
            end else if (push && full && !pop) begin
                pif.fifo_ovf <= 1'b1;
            end
        end
    end
`else
    logic unused_fifo;

    assign pif.fifo_valid = 1'b0;
    assign pif.fifo_dout  = '0;
    assign pif.fifo_ovf   = 1'b0;
    assign unused_fifo    = pif.fifo_rd ^ pif.ovf_clr ^ (FIFO_DEPTH != 0);
`endif
endmodule

// File: tb/tb_ear_pulse_conditioner.sv
// tb/tb_ear_pulse_conditioner.sv - self-checking bench for ear_pulse_conditioner
module tb_ear_pulse_conditioner;
    localparam int S    = 2;
    localparam int G    = 16;
    localparam int W    = 16;
    localparam int D    = 4;
    localparam int MAXW = (1 << W) - 1;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic ear_raw = 1'b0;
    logic ear, edge_stb, idle;

    ear_pulse_conditioner_if #(.WIDTH_BITS(W)) pif ();

    ear_pulse_conditioner #(
        .SYNC_STAGES(S), .GLITCH_CYCLES(G), .WIDTH_BITS(W), .FIFO_DEPTH(D)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ear_raw (ear_raw),
        .ear     (ear),
        .edge_stb(edge_stb),
        .idle    (idle),
        .pif     (pif)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit lvl;
        int len;
        bit exp_pulse;
        int exp_at;
        int exp_w;
        bit exp_l;
    } vec_t;

    typedef struct {
        int at;
        int w;
        bit l;
    } pulse_t;

    int nvec = 0;
    int nerr = 0;

    // reference model: ear flips once the delayed input has disagreed for G samples
    bit       rq[$];
    int       cyc;
    bit       m_ear, m_any, m_pv, m_l, m_s, m_idle, m_ovf, m_pend;
    int       m_w, last_e;
    bit [W:0] mq[$];
    pulse_t   obs[$];

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        repeat (S + G) rq.push_back(1'b0);
        cyc = 0; m_ear = 0; m_any = 0; m_pv = 0; m_l = 0; m_s = 0; m_idle = 1;
        m_w = 0; last_e = 0; m_ovf = 0; m_pend = 0;
        mq.delete();
    endtask

    task automatic tick(input bit raw, input bit rd, input bit clr);
        bit flip;
        int d;
        int sz;
        bit popok;
        ear_raw     = raw;
        pif.fifo_rd = rd;
        pif.ovf_clr = clr;
        @(posedge clk_sys);
        cyc++;
        rq.push_back(raw);
`ifdef EAR_PULSE_FIFO_EN
        sz    = mq.size();
        popok = rd && (sz > 0);
        if (popok) void'(mq.pop_front());
        if (m_pend) begin
            if (sz < D || popok) mq.push_back({m_l, W'(m_w)});
            else m_ovf = 1;
        end
        if (clr) m_ovf = 0;
`else
        sz    = 0;
        popok = 0;
`endif
        flip = 1;
        for (int j = 0; j < G; j++)
            if (rq[rq.size() - 1 - S - j] == m_ear) flip = 0;
        m_pv   = flip;
        m_pend = flip;
        if (flip) begin
            d      = cyc - last_e;
            m_w    = (d > MAXW) ? MAXW : d;
            m_s    = (d > MAXW);
            m_l    = m_ear;
            m_ear  = !m_ear;
            last_e = cyc;
            m_any  = 1;
        end
        m_idle = !m_any || (cyc - last_e >= MAXW);
        void'(rq.pop_front());
        #1;
        check("ear", ear, m_ear);
        check("edge_stb", edge_stb, m_pv);
        check("pulse_valid", pif.pulse_valid, m_pv);
        check("pulse_width", pif.pulse_width, m_w);
        check("pulse_level", pif.pulse_level, m_l);
        check("pulse_sat", pif.pulse_sat, m_s);
        check("idle", idle, m_idle);
        check("fifo_valid", pif.fifo_valid, mq.size() > 0);
        check("fifo_ovf", pif.fifo_ovf, m_ovf);
`ifdef EAR_PULSE_FIFO_EN
        if (mq.size() > 0) check("fifo_dout", pif.fifo_dout, mq[0]);
`else
        check("fifo_dout", pif.fifo_dout, 0);
`endif
        if (pif.pulse_valid) obs.push_back('{cyc, int'(pif.pulse_width), pif.pulse_level});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ear"}, ear, 0);
        check({tag, "_edge"}, edge_stb, 0);
        check({tag, "_pv"}, pif.pulse_valid, 0);
        check({tag, "_width"}, pif.pulse_width, 0);
        check({tag, "_level"}, pif.pulse_level, 0);
        check({tag, "_sat"}, pif.pulse_sat, 0);
        check({tag, "_idle"}, idle, 1);
        check({tag, "_fvalid"}, pif.fifo_valid, 0);
        check({tag, "_fovf"}, pif.fifo_ovf, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset_values(tag);
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        model_reset();
        obs.delete();
    endtask

    task automatic wait_pulse(input bit raw, input string tag, output bit found);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(raw, 1'b0, 1'b0);
            if (pif.pulse_valid) found = 1;
        end
        check({tag, "_seen"}, found, 1);
    endtask

    vec_t tbl[12];

    initial begin
        int ei;
        int done;
        int cnt;
        bit found;
        bit lv;
        int ln;

        tbl[0]  = '{0, 100,  0, 0,    0,    0};
        tbl[1]  = '{1, 1000, 1, 118,  118,  0};
        tbl[2]  = '{0, 500,  1, 1118, 1000, 1};
        tbl[3]  = '{1, 16,   1, 1618, 500,  0};
        tbl[4]  = '{0, 300,  1, 1634, 16,   1};
        tbl[5]  = '{1, 15,   0, 0,    0,    0};
        tbl[6]  = '{0, 200,  0, 0,    0,    0};
        tbl[7]  = '{1, 400,  1, 2149, 515,  0};
        tbl[8]  = '{0, 15,   0, 0,    0,    0};
        tbl[9]  = '{1, 300,  0, 0,    0,    0};
        tbl[10] = '{0, 20,   1, 2864, 715,  1};
        tbl[11] = '{1, 100,  1, 2884, 20,   0};

        pif.fifo_rd = 1'b0;
        pif.ovf_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_values("por");
        @(negedge clk_sys);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            for (int k = 0; k < tbl[i].len; k++) tick(tbl[i].lvl, 1'b0, 1'b0);
        ei = 0;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].exp_pulse) begin
                if (ei < obs.size()) begin
                    check("tbl_at", obs[ei].at, tbl[i].exp_at);
                    check("tbl_width", obs[ei].w, tbl[i].exp_w);
                    check("tbl_level", obs[ei].l, tbl[i].exp_l);
                end else begin
                    check("tbl_missing_pulse", 0, 1);
                end
                ei++;
            end
        end
        check("tbl_pulse_count", obs.size(), ei);

        done = 0;
        while (done < 2000) begin
            lv = 1'($urandom_range(0, 1));
            ln = $urandom_range(1, 40);
            for (int k = 0; k < ln; k++)
                tick(lv, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            done += ln;
        end

        repeat (100) tick(1'b1, 1'b0, 1'b0);
        repeat (MAXW + 30) tick(1'b0, 1'b0, 1'b0);
        check("long_idle", idle, 1);
        obs.delete();
        wait_pulse(1'b1, "long", found);
        if (found) begin
            check("long_width", obs[0].w, MAXW);
            check("long_sat", pif.pulse_sat, 1);
            check("long_idle_clr", idle, 0);
            check("long_level", obs[0].l, 0);
        end

`ifdef EAR_PULSE_FIFO_EN
        do_reset("f_rst");
        repeat (30) tick(1'b0, 1'b0, 1'b0);
        repeat (40) tick(1'b1, 1'b0, 1'b0);
        repeat (50) tick(1'b0, 1'b0, 1'b0);
        repeat (60) tick(1'b1, 1'b0, 1'b0);
        repeat (70) tick(1'b0, 1'b0, 1'b0);
        repeat (80) tick(1'b1, 1'b0, 1'b0);
        check("t5_ovf_set", pif.fifo_ovf, 1);
        tick(1'b1, 1'b0, 1'b1);
        check("t5_ovf_clr", pif.fifo_ovf, 0);
        check("t5_head0", pif.fifo_dout, {1'b0, 16'd48});
        tick(1'b1, 1'b1, 1'b0);
        check("t5_head1", pif.fifo_dout, {1'b1, 16'd40});
        tick(1'b1, 1'b1, 1'b0);
        check("t5_head2", pif.fifo_dout, {1'b0, 16'd50});
        tick(1'b1, 1'b1, 1'b0);
        check("t5_head3", pif.fifo_dout, {1'b1, 16'd60});
        tick(1'b1, 1'b1, 1'b0);
        check("t5_empty", pif.fifo_valid, 0);
        tick(1'b1, 1'b1, 1'b0);
        check("t5_pop_empty", pif.fifo_valid, 0);

        repeat (30) tick(1'b0, 1'b0, 1'b0);
        repeat (30) tick(1'b1, 1'b0, 1'b0);
        repeat (30) tick(1'b0, 1'b0, 1'b0);
        repeat (30) tick(1'b1, 1'b0, 1'b0);
        wait_pulse(1'b0, "t6", found);
        tick(1'b0, 1'b1, 1'b0);
        check("t6_ovf", pif.fifo_ovf, 0);
        check("t6_valid", pif.fifo_valid, 1);
        cnt = 0;
        for (int k = 0; k < 8 && pif.fifo_valid; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            cnt++;
        end
        check("t6_count", cnt, 4);
        check("t6_ovf_end", pif.fifo_ovf, 0);
`endif

        repeat (30) tick(1'b1, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        do_reset("mid_rst");
        wait_pulse(1'b1, "post_rst", found);
        if (found) begin
            check("post_rst_at", obs[0].at, 18);
            check("post_rst_width", obs[0].w, 18);
            check("post_rst_level", obs[0].l, 0);
        end
        repeat (10) tick(1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
